brick_sort_engine: RTL and testbench
====================================

# brick_sort_engine

Sequential odd-even transposition (brick) sorter for a block of 2^LOG_INPUT_NUM words. It accepts one vector over a valid/ready handshake, runs a configurable number of alternating even/odd compare-exchange phases per clock on an internal register, and presents the sorted vector on a valid/ready output. It is the clocked, handshaked successor to the combinational even/odd compare stage in the sorting-network library, and adds multi-phase unrolling, backpressure and optional early termination.

## Interface
- LOG_INPUT_NUM, 4, log2 of element count N; ≥1.
- DATA_WIDTH, 32, bits per element.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.
- ASCENDING, 1, 1 = element 0 smallest, 0 = element 0 largest.
- STAGES_PER_CYCLE, 1, phases applied per clock; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_data  in  N*DATA_WIDTH  element i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- out_valid  out  1  sorted vector valid.
- out_ready  in  1  consumer accepts.
- out_data  out  N*DATA_WIDTH  sorted vector, same packing.
- busy  out  1  high in SORT or DONE.
- phases_used  out  LOG_INPUT_NUM+1  phases executed for the current output.

## Operation
- States: IDLE, SORT, DONE.
- IDLE: in_ready=1. in_valid&&in_ready loads in_data into the data register, clears phase counter and swap flags, → SORT.
- SORT: each clock applies STAGES_PER_CYCLE phases in sequence on the register. Phase p even: compare-exchange pairs (2i, 2i+1), i=0..N/2-1. Phase p odd: pairs (2i+1, 2i+2), i=0..N/2-2; elements 0 and N-1 pass through. Exchange occurs only when the pair is strictly out of order for ASCENDING; equal values never swap.
- Phases always start at 0 (even). Phase counter increments by STAGES_PER_CYCLE per clock. When it reaches N (or early exit fires), → DONE.
- DONE: out_valid=1, out_data = register, phases_used = final phase count. out_valid&&out_ready → IDLE. in_ready=0 (no overlap of input and output transactions).
- Compare: SIGNED=1 interprets elements as two's complement (0x80 < 0xFF < 0x00 at 8 bits); SIGNED=0 unsigned.
- N=2: odd phase is a no-op; N phases still counted.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, phases_used=0. Reset during SORT or DONE discards data; no output produced.
- Accept on edge t → out_valid high from edge t+N/STAGES_PER_CYCLE (without early exit). STAGES_PER_CYCLE=1, N=16: 16 cycles.
- out_data and phases_used are stable while out_valid=1 and out_ready=0 (indefinitely).
- in_valid during SORT/DONE is ignored; no acceptance.
- out_ready while not DONE is ignored.
- Accept cycle itself applies no phase; first phase occurs on the first SORT edge.

## Configuration
- BRICK_SORT_EARLY_EXIT_EN defined: engine records swap occurrence per phase. After any phase p≥1, if phase p and phase p-1 (one even, one odd) both made zero swaps, transition to DONE on that edge; phases_used = p+1. With STAGES_PER_CYCLE=2 the check uses the two phases of the same clock. Minimum phases_used = 2 (STAGES_PER_CYCLE=1: output 2 cycles after accept).
- Not defined: no swap tracking logic; always exactly N phases; phases_used always N.

## Test plan
- N=4, DATA_WIDTH=8, ascending unsigned, S=1: in elements {4,3,2,1} → out {1,2,3,4}, out_valid 4 cycles after accept, phases_used=4.
- SIGNED=1, N=4: {0xFF,0x05,0x00,0x80} → {0x80,0xFF,0x00,0x05}; ASCENDING=0 same input unsigned → {0xFF,0x80,0x05,0x00}.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_data/out_valid unchanged, in_ready=0, second in_valid not accepted until one cycle after out handshake.
- rst asserted 2 cycles into SORT → next cycle out_valid=0, in_ready=1, out_data=0; following vector sorts correctly.
- BRICK_SORT_EARLY_EXIT_EN, N=16, S=1, already-sorted input 0..15 → out_valid 2 cycles after accept, phases_used=2; reversed input → phases_used=16.
- S=2, N=16, random vectors with duplicates (1000 runs) → matches reference sort, latency 8 cycles without early exit.

Source files
------------

// File: rtl/brick_sort_engine.sv
// brick_sort_engine: sequential odd-even transposition (brick) sorter.
// Accepts one N = 2**LOG_INPUT_NUM element vector over valid/ready. It then applies
// STAGES_PER_CYCLE alternating even/odd compare-exchange phases per clock to an
// internal register and presents the sorted vector over valid/ready.
//
// Optional feature macro: BRICK_SORT_EARLY_EXIT_EN
//   When defined, the engine finishes early once an even and an odd phase in a row
//   both make zero swaps. The default build always runs exactly N phases.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     input vector valid
//   in_ready     engine can accept (IDLE only)
//   in_data      N*DATA_WIDTH; element i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   out_valid    sorted vector valid (DONE)
//   out_ready    consumer accepts
//   out_data     sorted vector, same packing
//   busy         high in SORT or DONE
//   phases_used  phases executed for the current output
module brick_sort_engine #(
  parameter int unsigned LOG_INPUT_NUM    = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned SIGNED           = 0,
  parameter int unsigned ASCENDING        = 1,
  parameter int unsigned STAGES_PER_CYCLE = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0] in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0] out_data,
  output logic                                   busy,
  output logic [LOG_INPUT_NUM:0]                 phases_used
);

  localparam int unsigned N  = 2 ** LOG_INPUT_NUM;
  localparam int unsigned VW = N * DATA_WIDTH;
  localparam int unsigned PW = LOG_INPUT_NUM + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   data_q, data_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [VW-1:0]   ph0_vec;
  logic [VW-1:0]   ph1_vec;
  logic [VW-1:0]   sorted_vec;
  logic            early_exit;

  // True when the pair (a at lower index, b at higher index) must be exchanged.
  // Strict comparison keeps equal values in place.
  function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return (ASCENDING != 0) ? gt : lt;
  endfunction

  // One brick phase: even phase pairs (0,1),(2,3)..; odd phase pairs (1,2),(3,4)..
  // so elements 0 and N-1 pass through an odd phase untouched.
  function automatic logic [VW-1:0] brick_phase(input logic [VW-1:0] v, input logic odd);
    logic [VW-1:0]         r;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    r = v;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      a = v[i*DATA_WIDTH +: DATA_WIDTH];
      b = v[(i+1)*DATA_WIDTH +: DATA_WIDTH];
      if ((i[0] == odd) && out_of_order(a, b)) begin
        r[i*DATA_WIDTH +: DATA_WIDTH]     = b;
        r[(i+1)*DATA_WIDTH +: DATA_WIDTH] = a;
      end
    end
    return r;
  endfunction

  // Phase network: the second phase is only selected for two phases per clock.
  always_comb begin
    ph0_vec    = brick_phase(data_q, phase_q[0]);
    ph1_vec    = brick_phase(ph0_vec, ~phase_q[0]);
    sorted_vec = (STAGES_PER_CYCLE == 2) ? ph1_vec : ph0_vec;
  end

`ifdef BRICK_SORT_EARLY_EXIT_EN
  // Swap tracking: with no ties ever exchanged, a phase swapped iff it changed the vector.
  logic prev_swap_q, prev_swap_d;
  logic swap0, swap1;

  always_comb begin
    swap0 = (ph0_vec != data_q);
    swap1 = (ph1_vec != ph0_vec);
    if (STAGES_PER_CYCLE == 2) begin
      early_exit = !swap0 && !swap1;
    end else begin
      early_exit = (phase_q != '0) && !swap0 && !prev_swap_q;
    end
  end
`else
  assign early_exit = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    phase_d = phase_q;
`ifdef BRICK_SORT_EARLY_EXIT_EN
    prev_swap_d = prev_swap_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          phase_d = '0;
`ifdef BRICK_SORT_EARLY_EXIT_EN
          prev_swap_d = 1'b0;
`endif
          state_d = SORT;
        end
      end
      SORT: begin
        data_d  = sorted_vec;
        phase_d = phase_q + PW'(STAGES_PER_CYCLE);
`ifdef BRICK_SORT_EARLY_EXIT_EN
        prev_swap_d = (STAGES_PER_CYCLE == 2) ? swap1 : swap0;
`endif
        if ((phase_d >= PW'(N)) || early_exit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      phase_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BRICK_SORT_EARLY_EXIT_EN
      prev_swap_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      phase_q     <= phase_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef BRICK_SORT_EARLY_EXIT_EN
      prev_swap_q <= prev_swap_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_data    = data_q;
  assign phases_used = phase_q;

endmodule

// File: tb/tb_brick_sort_engine.sv
// Bench for brick_sort_engine: five configurations side by side.
//   0: N=4  unsigned ascending  S=1
//   1: N=4  signed   ascending  S=1
//   2: N=4  unsigned descending S=1
//   3: N=16 unsigned ascending  S=2
//   4: N=16 unsigned ascending  S=1
module tb_brick_sort_engine;
  localparam int NI = 5;
`ifdef BRICK_SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         iv  [NI];
  logic         orr [NI];
  logic [127:0] id  [NI];
  wire          ir  [NI];
  wire          ov  [NI];
  wire          bz  [NI];
  wire  [127:0] od  [NI];
  wire  [4:0]   pu  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int unsigned LG = (k < 3) ? 2 : 4;
    localparam int unsigned SG = (k == 1) ? 1 : 0;
    localparam int unsigned AS = (k == 2) ? 0 : 1;
    localparam int unsigned SP = (k == 3) ? 2 : 1;
    localparam int unsigned NW = (2 ** LG) * 8;
    logic [NW-1:0] o;
    logic [LG:0]   p;
    brick_sort_engine #(
      .LOG_INPUT_NUM(LG), .DATA_WIDTH(8), .SIGNED(SG),
      .ASCENDING(AS), .STAGES_PER_CYCLE(SP)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[k]), .in_ready(ir[k]), .in_data(id[k][NW-1:0]),
      .out_valid(ov[k]), .out_ready(orr[k]), .out_data(o),
      .busy(bz[k]), .phases_used(p)
    );
    assign od[k] = 128'(o);
    assign pu[k] = 5'(p);
  end

  typedef struct {
    int           k;
    logic [127:0] din;
    logic [127:0] dexp;
    int           lat;
    int           ph;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pk4(input logic [7:0] e0, input logic [7:0] e1,
                                       input logic [7:0] e2, input logic [7:0] e3);
    return 128'({e3, e2, e1, e0});
  endfunction

  function automatic logic [127:0] ramp(input bit rev);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = rev ? 8'(15 - i) : 8'(i);
    return v;
  endfunction

  // Phase count for config 3 (N=16, two phases per clock, unsigned ascending).
  function automatic int model_ph2(input logic [127:0] v0);
    logic [7:0] a [16];
    logic [7:0] t;
    bit         sw0;
    bit         sw1;
    int         p;
    for (int i = 0; i < 16; i++) a[i] = v0[i*8 +: 8];
    if (!EE) return 16;
    p = 0;
    while (p < 16) begin
      sw0 = 1'b0;
      for (int i = 0; i < 15; i += 2)
        if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw0 = 1'b1; end
      sw1 = 1'b0;
      for (int i = 1; i < 15; i += 2)
        if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw1 = 1'b1; end
      p += 2;
      if (!sw0 && !sw1) break;
    end
    return p;
  endfunction

  task automatic start(input int k, input logic [127:0] din);
    id[k] = din;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  // Count clock edges after the accept edge until out_valid, bounded.
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", 128'(ov[k]), 128'(1));
  endtask

  task automatic take(input int k);
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = 1'b0;
  endtask

  task automatic run(input int k, input logic [127:0] din,
                     output logic [127:0] dout, output int lat, output logic [4:0] ph);
    chk("in_ready_idle", 128'(ir[k]), 128'(1));
    start(k, din);
    wait_out(k, lat);
    dout = od[k];
    ph   = pu[k];
    take(k);
  endtask

  vec_t         tv [10];
  logic [127:0] dout;
  logic [127:0] din;
  logic [127:0] dexp;
  int           lat;
  logic [4:0]   ph;
  logic [7:0]   e [16];
  logic [7:0]   t;

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv[k]  = 1'b0;
      orr[k] = 1'b0;
      id[k]  = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_in_ready%0d", k), 128'(ir[k]), 128'(1));
      chk($sformatf("rst_out_valid%0d", k), 128'(ov[k]), 128'(0));
      chk($sformatf("rst_busy%0d", k), 128'(bz[k]), 128'(0));
      chk($sformatf("rst_out_data%0d", k), od[k], 128'(0));
      chk($sformatf("rst_phases%0d", k), 128'(pu[k]), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    tv[0] = '{0, pk4(8'd4, 8'd3, 8'd2, 8'd1), pk4(8'd1, 8'd2, 8'd3, 8'd4), 4, 4};
    tv[1] = '{1, pk4(8'hFF, 8'h05, 8'h00, 8'h80), pk4(8'h80, 8'hFF, 8'h00, 8'h05), 4, 4};
    tv[2] = '{2, pk4(8'hFF, 8'h05, 8'h00, 8'h80), pk4(8'hFF, 8'h80, 8'h05, 8'h00), 4, 4};
    tv[3] = '{0, pk4(8'd7, 8'd7, 8'd7, 8'd7), pk4(8'd7, 8'd7, 8'd7, 8'd7), EE ? 2 : 4, EE ? 2 : 4};
    tv[4] = '{0, pk4(8'd2, 8'd9, 8'd2, 8'd0), pk4(8'd0, 8'd2, 8'd2, 8'd9), 4, 4};
    tv[5] = '{1, pk4(8'h01, 8'hFE, 8'h7F, 8'h80), pk4(8'h80, 8'hFE, 8'h01, 8'h7F), 4, 4};
    tv[6] = '{4, ramp(1'b0), ramp(1'b0), EE ? 2 : 16, EE ? 2 : 16};
    tv[7] = '{4, ramp(1'b1), ramp(1'b0), 16, 16};
    tv[8] = '{3, ramp(1'b0), ramp(1'b0), EE ? 1 : 8, EE ? 2 : 16};
    tv[9] = '{3, ramp(1'b1), ramp(1'b0), 8, 16};

    for (int v = 0; v < 10; v++) begin
      run(tv[v].k, tv[v].din, dout, lat, ph);
      chk($sformatf("vec%0d_data", v), dout, tv[v].dexp);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(tv[v].lat));
      chk($sformatf("vec%0d_phases", v), 128'(ph), 128'(tv[v].ph));
    end

    // Backpressure: output held for 3 cycles, a second vector waits for IDLE.
    start(0, pk4(8'd4, 8'd3, 8'd2, 8'd1));
    repeat (4) @(negedge clk);
    chk("bp_first_valid", 128'(ov[0]), 128'(1));
    id[0] = pk4(8'd2, 8'd9, 8'd2, 8'd0);
    iv[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(ov[0]), 128'(1));
      chk("bp_data_held", od[0], pk4(8'd1, 8'd2, 8'd3, 8'd4));
      chk("bp_phases_held", 128'(pu[0]), 128'(4));
      chk("bp_in_ready_low", 128'(ir[0]), 128'(0));
    end
    take(0);
    chk("bp_after_hs_in_ready", 128'(ir[0]), 128'(1));
    chk("bp_after_hs_out_valid", 128'(ov[0]), 128'(0));
    chk("bp_after_hs_busy", 128'(bz[0]), 128'(0));
    @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_second_accepted", 128'(bz[0]), 128'(1));
    wait_out(0, lat);
    chk("bp_second_latency", 128'(lat), 128'(4));
    chk("bp_second_data", od[0], pk4(8'd0, 8'd2, 8'd2, 8'd9));
    take(0);

    // Reset two cycles into SORT discards the vector; out_ready during SORT is ignored.
    start(0, pk4(8'd4, 8'd3, 8'd2, 8'd1));
    orr[0] = 1'b1;
    repeat (2) @(negedge clk);
    orr[0] = 1'b0;
    chk("mid_sort_busy", 128'(bz[0]), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", 128'(ov[0]), 128'(0));
    chk("mid_rst_in_ready", 128'(ir[0]), 128'(1));
    chk("mid_rst_out_data", od[0], 128'(0));
    chk("mid_rst_phases", 128'(pu[0]), 128'(0));
    run(0, pk4(8'd9, 8'd1, 8'd5, 8'd3), dout, lat, ph);
    chk("post_rst_data", dout, pk4(8'd1, 8'd3, 8'd5, 8'd9));
    chk("post_rst_latency", 128'(lat), 128'(4));

    // Random vectors with duplicates on the two-phases-per-clock engine.
    for (int r = 0; r < 1000; r++) begin
      din = '0;
      for (int i = 0; i < 16; i++) begin
        e[i] = 8'($urandom_range(0, 15));
        din[i*8 +: 8] = e[i];
      end
      for (int i = 0; i < 15; i++)
        for (int j = 0; j < 15 - i; j++)
          if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
      dexp = '0;
      for (int i = 0; i < 16; i++) dexp[i*8 +: 8] = e[i];
      run(3, din, dout, lat, ph);
      chk($sformatf("rand%0d_data", r), dout, dexp);
      chk($sformatf("rand%0d_phases", r), 128'(ph), 128'(model_ph2(din)));
      chk($sformatf("rand%0d_latency", r), 128'(lat * 2), 128'(model_ph2(din)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
